// File: rtl/led_pkg.sv
// led_pkg: shared encodings and defaults for the LED blink sequencer
package led_pkg;

  localparam int PRESCALE_DEF = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ON_PH  = 2'b01,
    OFF_PH = 2'b10
  } state_e;

  function automatic logic is_seq(input mode_e m);
    return (m == MODE_BLINK) || (m == MODE_BURST);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing one tick every PRESCALE cycles, with sync clear
module led_tick_gen
  import led_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(PRESCALE);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(PRESCALE - 1);
  assign cnt_d = (clr_i | tick_o) ? '0 : cnt_q + W'(1);
  // prescaler count register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: command-driven LED controller with static, blink and burst modes
module led_blink_sequencer
  import led_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic [CNT_W-1:0] i_cmd_on_len,
  input  logic [CNT_W-1:0] i_cmd_off_len,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic             i_abort,
  output logic             o_led,
  output logic             o_busy,
  output logic             o_done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e state_q, state_d;
  mode_e mode_q, mode_d, cmd_mode;
  logic [CNT_W-1:0] on_len_q, on_len_d, off_len_q, off_len_d, count_q, count_d;
  logic [CNT_W-1:0] phase_q, phase_d, pulse_q, pulse_d;
  logic level_q, level_d, led_q, led_d, busy_q, busy_d, done_q, done_d;
  logic tick, accept, start, burst_empty, phase_end, last_pulse;

  // a zero-length phase behaves as a one-tick phase
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  assign cmd_mode    = mode_e'(i_cmd_mode);
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign burst_empty = (cmd_mode == MODE_BURST) & (i_cmd_count == '0);
  assign start       = accept & is_seq(cmd_mode) & ~burst_empty;
  assign phase_end   = tick & (phase_q == ONE) & (state_q != IDLE);
  assign last_pulse  = (mode_q == MODE_BURST) & (pulse_q == count_q - ONE);

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk_i (i_clock),
    .rst_ni(i_reset_n),
    .clr_i (accept | i_abort | (state_q == IDLE)),
    .tick_o(tick)
  );

  // state and datapath registers
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_OFF;
      on_len_q  <= '0;
      off_len_q <= '0;
      count_q   <= '0;
      phase_q   <= '0;
      pulse_q   <= '0;
      level_q   <= 1'b0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      on_len_q  <= on_len_d;
      off_len_q <= off_len_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      pulse_q   <= pulse_d;
      level_q   <= level_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end

  // next state: abort beats commands, commands beat phase timing
  always_comb
    state_d = i_abort ? IDLE :
              accept ? (start ? ON_PH : IDLE) :
              phase_end ? ((state_q == OFF_PH) ? ON_PH : last_pulse ? IDLE : OFF_PH) :
              state_q;

  // command latching, phase/pulse counters, static level and burst completion
  always_comb begin
    mode_d    = mode_q;
    on_len_d  = on_len_q;
    off_len_d = off_len_q;
    count_d   = count_q;
    phase_d   = phase_q;
    pulse_d   = pulse_q;
    level_d   = level_q;
    done_d    = 1'b0;
    if (i_abort) begin
      mode_d  = MODE_OFF;
      phase_d = '0;
      pulse_d = '0;
      level_d = 1'b0;
    end else if (accept) begin
      mode_d    = cmd_mode;
      on_len_d  = nz(i_cmd_on_len);
      off_len_d = nz(i_cmd_off_len);
      count_d   = i_cmd_count;
      phase_d   = nz(i_cmd_on_len);
      pulse_d   = '0;
      level_d   = cmd_mode == MODE_ON;
      done_d    = burst_empty;
    end else if (phase_end) begin
      done_d  = (state_q == ON_PH) & last_pulse;
      phase_d = (state_q == OFF_PH) ? on_len_q : last_pulse ? '0 : off_len_q;
      pulse_d = (state_q == ON_PH) ? pulse_q + ONE : pulse_q;
      level_d = done_d ? 1'b0 : level_q;
    end else if (tick & (state_q != IDLE)) begin
      phase_d = phase_q - ONE;
    end
  end

  // ready handshake and registered output levels
  always_comb begin
    o_cmd_ready = i_reset_n & ~i_abort & ((state_q == IDLE) | (mode_q == MODE_BLINK));
    led_d       = (state_d == ON_PH) | ((state_d == IDLE) & level_d);
    busy_d      = state_d != IDLE;
  end

endmodule
